fir_filter_param: RTL

Parametrised successor to the fixed 8-bit filter. It sequences an AD7822-style ADC and an AD7302-style DAC at a programmable sample rate and runs an NTAPS-tap FIR on each sample using a serial multiply-accumulate. Coefficients are runtime-writable through a shadow bank. Sits between the ADC and DAC models in the decoder filter bench and on the board.

---
 rtl/fir_filter_param.sv | 245 ++++++++++++++++++++++++
 1 files changed

// File: rtl/fir_filter_param.sv
// fir_filter_param: sequences an AD7822-style ADC and an AD7302-style DAC at a
// fixed sample rate and runs an NTAPS-tap FIR on every sample using one serial
// multiply-accumulate per clock. Coefficients are written into a shadow bank
// and copied into the active bank only on the sample-latch cycle.
// Optional feature macro: FILTER_BYPASS_EN (adds the bypass input).
module fir_filter_param #(
   parameter int DATA_W      = 8,
   parameter int NTAPS       = 8,
   parameter int COEF_W      = 10,
   parameter int SHIFT       = 6,
   parameter int SAMPLE_DIV  = 1000,
   parameter int CONVST_CYC  = 2,
   parameter int RD_CYC      = 3,
   parameter int WR_CYC      = 3,
   parameter int EOC_TIMEOUT = 255
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [DATA_W-1:0]          filter_in,
   input  logic                       adc_eoc_n,
   output logic                       adc_convst_n,
   output logic                       adc_cs_n,
   output logic                       adc_rd_n,
   output logic [DATA_W-1:0]          filter_out,
   output logic                       dac_cs_n,
   output logic                       dac_wr_n,
   output logic                       dac_load_n,
   output logic                       dac_clear_n,
   input  logic                       coef_we,
   input  logic [$clog2(NTAPS)-1:0]   coef_addr,
   input  logic signed [COEF_W-1:0]   coef_data,
   input  logic                       coef_commit,
   output logic                       busy,
   output logic                       overrun,
   output logic                       eoc_err
`ifdef FILTER_BYPASS_EN
   ,
   input  logic                       bypass
`endif
);

   localparam int TAP_W  = $clog2(NTAPS);
   localparam int ACC_W  = DATA_W + COEF_W + TAP_W + 1;
   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam int CNT_W  = 16;

   localparam logic signed [COEF_W-1:0] COEF_UNITY = COEF_W'(1 << SHIFT);
   localparam logic signed [ACC_W-1:0]  SAT_MAX    = ACC_W'((1 << DATA_W) - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CONV, S_WAIT_EOC, S_READ, S_MAC, S_SAT, S_WRITE, S_LOAD
   } state_t;

   state_t                    state, state_nx;
   logic [CNT_W-1:0]          cnt;
   logic [DIV_W-1:0]          div_cnt;
   logic                      tick;
   logic                      latch;
   logic                      eoc_timeout;
   logic                      commit_pend;
   logic signed [COEF_W-1:0]  shadow    [NTAPS];
   logic signed [COEF_W-1:0]  shadow_nx [NTAPS];
   logic signed [COEF_W-1:0]  active    [NTAPS];
   logic [DATA_W-1:0]         tap       [NTAPS];
   logic [TAP_W-1:0]          idx;
   logic signed [PROD_W-1:0]  prod;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   shifted;
   logic [DATA_W-1:0]         sat_val;
   logic [DATA_W-1:0]         out_val;

   assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));
   assign busy = (state != S_IDLE);
   assign idx  = cnt[TAP_W-1:0];

   // Free-running sample-rate divider; tick marks the last count of each period.
   always_ff @(posedge clk) begin
      // NOTE: every sequential block uses non-blocking assignments so all flops
      // sample pre-edge values; blocking here would create order-dependent races.
      if (reset)
         div_cnt <= '0;
      else if (tick)
         div_cnt <= '0;
      else
         div_cnt <= div_cnt + DIV_W'(1);
   end

   // State register plus the per-state cycle counter (restarts on every state change).
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nx;
         if (state_nx != state || state == S_IDLE)
            cnt <= '0;
         else
            cnt <= cnt + CNT_W'(1);
      end
   end

   // Next-state decode; latch and eoc_timeout are single-cycle event strobes.
   always_comb begin
      // NOTE: defaults first so no path leaves a variable unassigned, which
      // would otherwise infer a latch.
      state_nx    = state;
      latch       = 1'b0;
      eoc_timeout = 1'b0;
      case (state)
         S_IDLE:     if (tick) state_nx = S_CONV;
         S_CONV:     if (cnt == CNT_W'(CONVST_CYC - 1)) state_nx = S_WAIT_EOC;
         S_WAIT_EOC: begin
            if (!adc_eoc_n) begin
               state_nx = S_READ;
            end else if (cnt == CNT_W'(EOC_TIMEOUT - 1)) begin
               eoc_timeout = 1'b1;
               state_nx    = S_IDLE;
            end
         end
         S_READ: begin
            if (cnt == CNT_W'(RD_CYC - 1)) begin
               latch    = 1'b1;
               state_nx = S_MAC;
            end
         end
         S_MAC:      if (cnt == CNT_W'(NTAPS - 1)) state_nx = S_SAT;
         S_SAT:      state_nx = S_WRITE;
         S_WRITE:    if (cnt == CNT_W'(WR_CYC - 1)) state_nx = S_LOAD;
         S_LOAD:     state_nx = S_IDLE;
         default:    state_nx = S_IDLE;
      endcase
   end

   // Interface strobes are registered from the next state so they are glitch-free
   // and line up exactly with the state they belong to.
   always_ff @(posedge clk) begin
      if (reset) begin
         adc_convst_n <= 1'b1;
         adc_cs_n     <= 1'b1;
         adc_rd_n     <= 1'b1;
         dac_cs_n     <= 1'b1;
         dac_wr_n     <= 1'b1;
         dac_load_n   <= 1'b1;
         dac_clear_n  <= 1'b0;
      end else begin
         adc_convst_n <= (state_nx != S_CONV);
         adc_cs_n     <= (state_nx != S_READ);
         adc_rd_n     <= (state_nx != S_READ);
         dac_cs_n     <= (state_nx != S_WRITE);
         dac_wr_n     <= (state_nx != S_WRITE);
         dac_load_n   <= (state_nx != S_LOAD);
         dac_clear_n  <= 1'b1;
      end
   end

   // Sticky fault flags; only reset clears them.
   always_ff @(posedge clk) begin
      if (reset) begin
         overrun <= 1'b0;
         eoc_err <= 1'b0;
      end else begin
         if (tick && busy) overrun <= 1'b1;
         if (eoc_timeout)  eoc_err <= 1'b1;
      end
   end

   // Shadow bank with this cycle's write merged in, so a commit issued together
   // with a write (or on the latch cycle itself) picks that write up.
   always_comb begin
      shadow_nx = shadow;
      if (coef_we) shadow_nx[coef_addr] = coef_data;
   end

   // Coefficient banks: the active bank only changes on the sample-latch cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: both banks are reset deliberately (identity filter), so they
         // are built from flops rather than an un-resettable RAM.
         for (int i = 0; i < NTAPS; i++) begin
            shadow[i] <= (i == 0) ? COEF_UNITY : '0;
            active[i] <= (i == 0) ? COEF_UNITY : '0;
         end
         commit_pend <= 1'b0;
      end else begin
         shadow <= shadow_nx;
         if (latch) begin
            if (commit_pend || coef_commit) active <= shadow_nx;
            commit_pend <= 1'b0;
         end else if (coef_commit) begin
            commit_pend <= 1'b1;
         end
      end
   end

   // Delay line: shifts only when a sample is actually read from the ADC.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NTAPS; i++) tap[i] <= '0;
      end else if (latch) begin
         for (int i = NTAPS - 1; i > 0; i--) tap[i] <= tap[i-1];
         tap[0] <= filter_in;
      end
   end

   // One signed product per MAC cycle; taps are zero-extended unsigned.
   always_comb begin
      prod = PROD_W'(active[idx]) * PROD_W'($signed({1'b0, tap[idx]}));
   end

   // Accumulator is cleared as MAC is entered and sums one tap per cycle.
   always_ff @(posedge clk) begin
      if (reset)
         acc <= '0;
      else if (latch)
         acc <= '0;
      else if (state == S_MAC)
         acc <= acc + ACC_W'(prod);
   end

   // Scale and clamp the accumulator to the unsigned DAC range.
   always_comb begin
      shifted = acc >>> SHIFT;
      if (shifted[ACC_W-1])
         sat_val = '0;
      else if (shifted > SAT_MAX)
         sat_val = '1;
      else
         sat_val = shifted[DATA_W-1:0];
`ifdef FILTER_BYPASS_EN
      out_val = bypass ? tap[0] : sat_val;
`else
      out_val = sat_val;
`endif
   end

   // DAC data is registered in SAT and held through WRITE and LOAD.
   always_ff @(posedge clk) begin
      if (reset)
         filter_out <= '0;
      else if (state == S_SAT)
         filter_out <= out_val;
   end

endmodule
